// File: rtl/csr_unit.sv
// ----------------------------------------------------------------------------
// csr_unit -- machine-mode CSR file for the OTTER multicycle core.
//
// Holds mstatus (MIE/MPIE), mie, mtvec, mscratch, mepc, mcause, mip and the
// 64-bit mcycle/minstret counters.  Software accesses use CSRRW/CSRRS/CSRRC
// semantics with a combinational read of the pre-write value.  NUM_IRQ level
// interrupt lines are registered into mip and prioritised lowest-index-first.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   csr_addr      12-bit CSR address
//   csr_op        00 none, 01 RW, 10 RS, 11 RC
//   csr_wd        write operand (rs1 or zimm)
//   csr_rd        current (pre-write) value of the addressed CSR
//   irq           level interrupt requests
//   instret_inc   one instruction retired this cycle
//   int_taken     control FSM entering a trap
//   int_ret       control FSM executing mret
//   next_pc       PC saved into mepc on a trap
//   int_pending   trap requested (global enable and an enabled pending line)
//   mepc, mtvec   trap return address / handler base for the PC mux
// ----------------------------------------------------------------------------
module csr_unit #(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          COUNTERS_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        csr_addr,
    input  logic [1:0]         csr_op,
    input  logic [31:0]        csr_wd,
    output logic [31:0]        csr_rd,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               instret_inc,
    input  logic               int_taken,
    input  logic               int_ret,
    input  logic [31:0]        next_pc,
    output logic               int_pending,
    output logic [31:0]        mepc,
    output logic [31:0]        mtvec
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    logic               st_mie_q;
    logic               st_mpie_q;
    logic [NUM_IRQ-1:0] mie_q;
    logic [NUM_IRQ-1:0] mip_q;
    logic [31:0]        mtvec_q;
    logic [31:0]        mscratch_q;
    logic [31:0]        mepc_q;
    logic [31:0]        mcause_q;
    logic [63:0]        mcycle_q;
    logic [63:0]        minstret_q;

    logic [31:0]        rd_val;
    logic [31:0]        wr_val;
    logic               wr_en;
    logic [NUM_IRQ-1:0] pend_vec;
    logic [3:0]         win_idx;

    // Combinational read of the addressed CSR (value before this cycle's write)
    always_comb begin
        rd_val = '0;
        case (csr_addr)
            A_MSTATUS:   rd_val = {24'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
            A_MIE:       rd_val = {{(32-NUM_IRQ){1'b0}}, mie_q};
            A_MTVEC:     rd_val = mtvec_q;
            A_MSCRATCH:  rd_val = mscratch_q;
            A_MEPC:      rd_val = mepc_q;
            A_MCAUSE:    rd_val = mcause_q;
            A_MIP:       rd_val = {{(32-NUM_IRQ){1'b0}}, mip_q};
            A_MCYCLE:    rd_val = mcycle_q[31:0];
            A_MCYCLEH:   rd_val = mcycle_q[63:32];
            A_MINSTRET:  rd_val = minstret_q[31:0];
            A_MINSTRETH: rd_val = minstret_q[63:32];
            default:     rd_val = '0;
        endcase
    end

    // New value for the addressed CSR; RS/RC merge with the old value
    always_comb begin
        case (csr_op)
            2'b01:   wr_val = csr_wd;
            2'b10:   wr_val = rd_val | csr_wd;
            2'b11:   wr_val = rd_val & ~csr_wd;
            default: wr_val = rd_val;
        endcase
    end

    assign wr_en = (csr_op != 2'b00);

    // Lowest enabled pending index wins: scan downwards so the last hit is lowest
    always_comb begin
        pend_vec = mip_q & mie_q;
        win_idx  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_vec[i]) win_idx = 4'(i);
        end
    end

    assign int_pending = st_mie_q & (|pend_vec);
    assign csr_rd      = rd_val;
    assign mepc        = mepc_q;
    assign mtvec       = mtvec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mip_q <= irq;

            // CSRs that trap events never touch
            if (wr_en) begin
                case (csr_addr)
                    A_MIE:      mie_q      <= wr_val[NUM_IRQ-1:0];
                    A_MTVEC:    mtvec_q    <= wr_val & ~32'h3;
                    A_MSCRATCH: mscratch_q <= wr_val;
                    default:    ;
                endcase
            end

            // Trap entry/return own mstatus, mepc and mcause for the cycle
            if (int_taken) begin
                mepc_q    <= next_pc & ~32'h3;
                mcause_q  <= {1'b1, 27'b0, win_idx};
                st_mpie_q <= st_mie_q;
                st_mie_q  <= 1'b0;
            end else if (int_ret) begin
                st_mie_q  <= st_mpie_q;
                st_mpie_q <= 1'b1;
            end else if (wr_en) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        st_mie_q  <= wr_val[3];
                        st_mpie_q <= wr_val[7];
                    end
                    A_MEPC:    mepc_q   <= wr_val & ~32'h3;
                    A_MCAUSE:  mcause_q <= wr_val;
                    default:   ;
                endcase
            end
        end
    end

    // A write to either half replaces that cycle's increment; the other half holds
    if (COUNTERS_EN) begin : g_counters
        always_ff @(posedge clk) begin
            if (rst) begin
                mcycle_q   <= '0;
                minstret_q <= '0;
            end else begin
                if (wr_en && csr_addr == A_MCYCLE)
                    mcycle_q[31:0] <= wr_val;
                else if (wr_en && csr_addr == A_MCYCLEH)
                    mcycle_q[63:32] <= wr_val;
                else
                    mcycle_q <= mcycle_q + 64'd1;

                if (wr_en && csr_addr == A_MINSTRET)
                    minstret_q[31:0] <= wr_val;
                else if (wr_en && csr_addr == A_MINSTRETH)
                    minstret_q[63:32] <= wr_val;
                else if (instret_inc)
                    minstret_q <= minstret_q + 64'd1;
            end
        end
    end else begin : g_no_counters
        assign mcycle_q   = '0;
        assign minstret_q = '0;
    end

endmodule

// File: tb/tb_csr_unit.sv
module tb_csr_unit;

    localparam int          NIRQ      = 4;
    localparam logic [31:0] MTVEC_RST = 32'h0000_1000;

    logic            clk;
    logic            rst;
    logic [11:0]     csr_addr;
    logic [1:0]      csr_op;
    logic [31:0]     csr_wd;
    logic [31:0]     csr_rd;
    logic [NIRQ-1:0] irq;
    logic            instret_inc;
    logic            int_taken;
    logic            int_ret;
    logic [31:0]     next_pc;
    logic            int_pending;
    logic [31:0]     mepc;
    logic [31:0]     mtvec;

    int n_cmp  = 0;
    int n_fail = 0;

    csr_unit #(
        .NUM_IRQ    (NIRQ),
        .MTVEC_RESET(MTVEC_RST),
        .COUNTERS_EN(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .csr_addr   (csr_addr),
        .csr_op     (csr_op),
        .csr_wd     (csr_wd),
        .csr_rd     (csr_rd),
        .irq        (irq),
        .instret_inc(instret_inc),
        .int_taken  (int_taken),
        .int_ret    (int_ret),
        .next_pc    (next_pc),
        .int_pending(int_pending),
        .mepc       (mepc),
        .mtvec      (mtvec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Combinational read with no write
    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        csr_addr = a;
        csr_op   = 2'b00;
        #1;
        v = csr_rd;
    endtask

    // One-cycle CSR access, op returned to none afterwards
    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_addr = a;
        csr_op   = op;
        csr_wd   = d;
        tick();
        csr_op = 2'b00;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        repeat (3) tick();
        rd(12'h305, v);
        n_cmp++; if (v !== MTVEC_RST) begin n_fail++; $display("FAIL rst_mtvec got %h exp %h", v, MTVEC_RST); end
        n_cmp++; if (mtvec !== MTVEC_RST) begin n_fail++; $display("FAIL rst_mtvec_port got %h exp %h", mtvec, MTVEC_RST); end
        rd(12'h300, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_mstatus got %h exp %h", v, 32'h0); end
        rd(12'h304, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_mie got %h exp %h", v, 32'h0); end
        rd(12'h341, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_mepc got %h exp %h", v, 32'h0); end
        rd(12'h342, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_mcause got %h exp %h", v, 32'h0); end
        rd(12'hB00, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_mcycle got %h exp %h", v, 32'h0); end
        n_cmp++; if (int_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending got %b exp %b", int_pending, 1'b0); end
        rst = 1'b0;
    endtask

    task automatic test_csr_ops();
        logic [31:0] v;
        csr_addr = 12'h340; csr_op = 2'b01; csr_wd = 32'hA5A5_0000; #1;
        n_cmp++; if (csr_rd !== 32'h0) begin n_fail++; $display("FAIL rw_old got %h exp %h", csr_rd, 32'h0); end
        tick();
        csr_op = 2'b10; csr_wd = 32'h0000_00FF; #1;
        n_cmp++; if (csr_rd !== 32'hA5A5_0000) begin n_fail++; $display("FAIL rs_old got %h exp %h", csr_rd, 32'hA5A5_0000); end
        tick();
        rd(12'h340, v);
        n_cmp++; if (v !== 32'hA5A5_00FF) begin n_fail++; $display("FAIL rs_new got %h exp %h", v, 32'hA5A5_00FF); end
        wr(12'h340, 2'b11, 32'hA500_0000);
        rd(12'h340, v);
        n_cmp++; if (v !== 32'h00A5_00FF) begin n_fail++; $display("FAIL rc_new got %h exp %h", v, 32'h00A5_00FF); end
        wr(12'h341, 2'b01, 32'hFFFF_FFFF);
        rd(12'h341, v);
        n_cmp++; if (v !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL mepc_align got %h exp %h", v, 32'hFFFF_FFFC); end
        n_cmp++; if (mepc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL mepc_port got %h exp %h", mepc, 32'hFFFF_FFFC); end
        wr(12'h305, 2'b01, 32'h0000_2003);
        n_cmp++; if (mtvec !== 32'h0000_2000) begin n_fail++; $display("FAIL mtvec_wr got %h exp %h", mtvec, 32'h0000_2000); end
        wr(12'h344, 2'b01, 32'hFFFF_FFFF);
        rd(12'h344, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL mip_ro got %h exp %h", v, 32'h0); end
        wr(12'h123, 2'b01, 32'hDEAD_BEEF);
        rd(12'h123, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped got %h exp %h", v, 32'h0); end
    endtask

    task automatic test_priority();
        logic [31:0] v;
        wr(12'h304, 2'b01, 32'h0000_000F);
        wr(12'h300, 2'b10, 32'h0000_0008);
        irq = 4'b1010; #1;
        n_cmp++; if (int_pending !== 1'b0) begin n_fail++; $display("FAIL pend_sync_delay got %b exp %b", int_pending, 1'b0); end
        tick();
        n_cmp++; if (int_pending !== 1'b1) begin n_fail++; $display("FAIL pend_rise got %b exp %b", int_pending, 1'b1); end
        int_taken = 1'b1; next_pc = 32'h0000_0100;
        tick();
        int_taken = 1'b0;
        n_cmp++; if (mepc !== 32'h0000_0100) begin n_fail++; $display("FAIL trap_mepc got %h exp %h", mepc, 32'h0000_0100); end
        rd(12'h342, v);
        n_cmp++; if (v !== 32'h8000_0001) begin n_fail++; $display("FAIL trap_mcause got %h exp %h", v, 32'h8000_0001); end
        rd(12'h300, v);
        n_cmp++; if (v !== 32'h0000_0080) begin n_fail++; $display("FAIL trap_mstatus got %h exp %h", v, 32'h0000_0080); end
        n_cmp++; if (int_pending !== 1'b0) begin n_fail++; $display("FAIL trap_pend_masked got %b exp %b", int_pending, 1'b0); end
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        rd(12'h300, v);
        n_cmp++; if (v !== 32'h0000_0088) begin n_fail++; $display("FAIL mret_mstatus got %h exp %h", v, 32'h0000_0088); end
        // With line 1 disabled, line 3 is the only enabled pending source
        wr(12'h304, 2'b01, 32'h0000_000C);
        int_taken = 1'b1; next_pc = 32'h0000_0104;
        tick();
        int_taken = 1'b0;
        rd(12'h342, v);
        n_cmp++; if (v !== 32'h8000_0003) begin n_fail++; $display("FAIL trap_idx3 got %h exp %h", v, 32'h8000_0003); end
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        irq = '0;
        repeat (2) tick();
    endtask

    task automatic test_masking();
        logic seen;
        irq = 4'b0100;
        wr(12'h304, 2'b01, 32'h0000_0003);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (int_pending !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mask_mie got %b exp %b", seen, 1'b0); end
        wr(12'h300, 2'b11, 32'h0000_0008);
        wr(12'h304, 2'b01, 32'h0000_000F);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (int_pending !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mask_global got %b exp %b", seen, 1'b0); end
        wr(12'h300, 2'b10, 32'h0000_0008);
        n_cmp++; if (int_pending !== 1'b1) begin n_fail++; $display("FAIL unmask_pend got %b exp %b", int_pending, 1'b1); end
        irq = '0;
        wr(12'h300, 2'b11, 32'h0000_0008);
        repeat (2) tick();
    endtask

    task automatic test_collision();
        logic [31:0] v;
        // Trap with nothing pending: idx 0, and it overrides the mepc write
        csr_addr = 12'h341; csr_op = 2'b01; csr_wd = 32'h0000_0200;
        int_taken = 1'b1; next_pc = 32'h0000_0300;
        tick();
        csr_op = 2'b00; int_taken = 1'b0;
        n_cmp++; if (mepc !== 32'h0000_0300) begin n_fail++; $display("FAIL coll_mepc got %h exp %h", mepc, 32'h0000_0300); end
        rd(12'h342, v);
        n_cmp++; if (v !== 32'h8000_0000) begin n_fail++; $display("FAIL coll_idx0 got %h exp %h", v, 32'h8000_0000); end
        // A write to an unrelated CSR still commits alongside a trap
        csr_addr = 12'h340; csr_op = 2'b01; csr_wd = 32'h0000_1234;
        int_taken = 1'b1; next_pc = 32'h0000_0400;
        tick();
        csr_op = 2'b00; int_taken = 1'b0;
        rd(12'h340, v);
        n_cmp++; if (v !== 32'h0000_1234) begin n_fail++; $display("FAIL coll_mscratch got %h exp %h", v, 32'h0000_1234); end
        wr(12'h300, 2'b10, 32'h0000_0008);
        int_taken = 1'b1; int_ret = 1'b1;
        tick();
        int_taken = 1'b0; int_ret = 1'b0;
        rd(12'h300, v);
        n_cmp++; if (v !== 32'h0000_0080) begin n_fail++; $display("FAIL coll_take_ret got %h exp %h", v, 32'h0000_0080); end
        // mret beats a same-cycle mstatus write: MIE <= MPIE(1), MPIE <= 1
        csr_addr = 12'h300; csr_op = 2'b01; csr_wd = 32'h0;
        int_ret = 1'b1;
        tick();
        csr_op = 2'b00; int_ret = 1'b0;
        rd(12'h300, v);
        n_cmp++; if (v !== 32'h0000_0088) begin n_fail++; $display("FAIL coll_ret_wr got %h exp %h", v, 32'h0000_0088); end
        wr(12'h300, 2'b01, 32'h0);
    endtask

    task automatic test_counters();
        logic [31:0] v;
        logic [11:0] pat;
        wr(12'hB00, 2'b01, 32'hFFFF_FFFE);
        repeat (2) tick();
        rd(12'hB00, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL mcycle_lo_carry got %h exp %h", v, 32'h0); end
        rd(12'hB80, v);
        n_cmp++; if (v !== 32'h1) begin n_fail++; $display("FAIL mcycle_hi_carry got %h exp %h", v, 32'h1); end
        // High-half write holds low half instead of incrementing it
        wr(12'hB80, 2'b01, 32'hFFFF_FFFF);
        rd(12'hB00, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL mcycle_hold_lo got %h exp %h", v, 32'h0); end
        wr(12'hB00, 2'b01, 32'hFFFF_FFFE);
        repeat (2) tick();
        rd(12'hB00, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap_lo got %h exp %h", v, 32'h0); end
        rd(12'hB80, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap_hi got %h exp %h", v, 32'h0); end
        rd(12'hB02, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL minstret_idle got %h exp %h", v, 32'h0); end
        pat = 12'b1000_1010_0101;
        for (int i = 0; i < 12; i++) begin
            instret_inc = pat[i];
            tick();
        end
        instret_inc = 1'b0;
        rd(12'hB02, v);
        n_cmp++; if (v !== 32'd5) begin n_fail++; $display("FAIL minstret_count got %h exp %h", v, 32'd5); end
        rd(12'hB82, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL minstret_hi got %h exp %h", v, 32'h0); end
    endtask

    task automatic test_reset_mid_trap();
        logic [31:0] v;
        wr(12'h342, 2'b01, 32'h0000_0055);
        rst = 1'b1; int_taken = 1'b1; next_pc = 32'h0000_0040;
        tick();
        rst = 1'b0; int_taken = 1'b0;
        n_cmp++; if (mepc !== 32'h0) begin n_fail++; $display("FAIL rst_trap_mepc got %h exp %h", mepc, 32'h0); end
        n_cmp++; if (mtvec !== MTVEC_RST) begin n_fail++; $display("FAIL rst_trap_mtvec got %h exp %h", mtvec, MTVEC_RST); end
        rd(12'h342, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_trap_mcause got %h exp %h", v, 32'h0); end
    endtask

    initial begin
        rst = 1'b1; csr_addr = '0; csr_op = 2'b00; csr_wd = '0; irq = '0;
        instret_inc = 1'b0; int_taken = 1'b0; int_ret = 1'b0; next_pc = '0;
        test_reset();
        test_csr_ops();
        test_priority();
        test_masking();
        test_collision();
        test_counters();
        test_reset_mid_trap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
